dnn_layer_ctrl: RTL and testbench
=================================

// Module: dnn_layer_ctrl
// PURPOSE
//  Sequencer for one pass of the 8-neuron MAC datapath (dnn_dp).
//  On start: clears the accumulators, streams N input vectors from an external x buffer, and waits out the array latency.
//  It then captures the 8 activations into a holding register and pulses done.
//  Sits between the AXI register/DMA front-end (start, n_vec, result read-back) and dnn_dp (en, clr, x operand select).
// PARAMETERS
//  DW      16  activation/operand width, signed Q5.10
//  NN      8   neurons per layer (activation lanes)
//  AW      8   x-buffer address width
//  DP_LAT  9   cycles from last x_rd_en to final a_in stable (1 buffer read + 8 array skew)
// PORTS
//  clk       in   1        clock, all logic rising-edge
//  rst_n     in   1        asynchronous active-low reset
//  start     in   1        begin a pass; sampled only in IDLE
//  abort     in   1        cancel current pass
//  n_vec     in   AW       input vectors to stream, latched at start
//  busy      out  1        high from start acceptance until done/abort
//  done      out  1        one-cycle pulse, a_out valid
//  x_rd_en   out  1        x-buffer read strobe (data valid next cycle)
//  x_rd_addr out  AW       x-buffer read address
//  x_zero    out  1        force dnn_dp x operands to 0 (drain/idle)
//  dp_en     out  1        dnn_dp accumulate enable
//  dp_clr    out  1        dnn_dp accumulator clear
//  a_in      in   NN*DW    packed a0..a7 from dnn_dp (a0 in LSBs)
//  a_out     out  NN*DW    captured activations, held until next capture
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, x_rd_en, dp_en and dp_clr are 0; x_zero=1; x_rd_addr=0; a_out=0; counters=0.
//  FSM IDLE->CLEAR->FEED->DRAIN->IDLE, all outputs registered:
//   IDLE:  start=1 & abort=0 -> CLEAR; latch n_vec; busy<=1.
//   CLEAR: 1 cycle; dp_clr=1, dp_en=1; x_rd_addr<=0. Next FEED, or DRAIN if n_vec==0.
//   FEED:  n_vec cycles; x_rd_en=1, dp_en=1.
//          x_rd_addr = 0..n_vec-1, +1 per cycle, no wrap (n_vec<=2^AW-1).
//   DRAIN: DP_LAT cycles; x_rd_en=0, dp_en=1.
//          On the last drain edge: a_out<=a_in, done<=1, busy<=0, dp_en<=0, state->IDLE.
//  x_zero = ~(x_rd_en delayed 1 cycle): low exactly when buffer read data is on the bus.
//  Latency: done is high in the cycle after edge (start edge + n_vec + DP_LAT + 1); one cycle only.
//  start while busy: ignored, no queueing. start held high: a new pass begins the cycle after done.
//  abort (any state != IDLE): next edge -> IDLE, then:
//   - busy, dp_en, dp_clr and x_rd_en are 0; x_zero=1;
//   - no done pulse; a_out unchanged.
//  abort in IDLE is a no-op; abort wins over a simultaneous start.
//  rst_n low mid-pass: immediate return to reset values, no done.
//  No arithmetic on a_in; a_out is a bit-exact copy (no saturation here).
// TESTING
//  1 Reset: rst_n=0 with start=1 -> all outputs at reset values, a_out=0, no read strobes.
//  2 n_vec=14, DP_LAT=9, start pulse at edge k -> dp_clr high only in cycle k+1.
//    x_rd_en high for 14 cycles (addr 0..13); done single pulse after edge k+24.
//    a_out equals the model result for the 14 skewed vectors (x0=512 first, 1.0=1024).
//  3 n_vec=0 -> CLEAR then 9 drain cycles, no x_rd_en.
//    done after edge k+10; a_out = zero after clear with zero operands.
//  4 abort during FEED at addr 5 -> IDLE next cycle, no done, a_out keeps previous pass value.
//    A following start runs a clean pass from addr 0.
//  5 start re-asserted while busy, and start+abort together in IDLE -> both ignored.
//    Exactly one done per accepted pass.
//  6 start held high for 3 passes, n_vec=2 -> done every 13 cycles; a_out updates each pass.

Source files
------------

// File: rtl/dnn_layer_ctrl.sv
// Pass sequencer for the 8-neuron MAC datapath (dnn_dp).
// Runs one layer pass in four steps: clear the accumulators, stream the x
// vectors, wait out the array latency, then capture the activations.
// Every output comes from a register.
module dnn_layer_ctrl #(
  parameter int DW     = 16,
  parameter int NN     = 8,
  parameter int AW     = 8,
  parameter int DP_LAT = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [AW-1:0]     n_vec,
  output logic              busy,
  output logic              done,
  output logic              x_rd_en,
  output logic [AW-1:0]     x_rd_addr,
  output logic              x_zero,
  output logic              dp_en,
  output logic              dp_clr,
  input  logic [NN*DW-1:0]  a_in,
  output logic [NN*DW-1:0]  a_out
);

  localparam int CW = $clog2(DP_LAT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   n_lat, n_lat_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            busy_nx, done_nx, x_rd_en_nx, x_zero_nx, dp_en_nx, dp_clr_nx;
  logic [AW-1:0]   x_rd_addr_nx;
  logic            capture;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx     = state;
    n_lat_nx     = n_lat;
    cnt_nx       = cnt;
    busy_nx      = busy;
    done_nx      = 1'b0;
    dp_clr_nx    = 1'b0;
    dp_en_nx     = dp_en;
    x_rd_en_nx   = x_rd_en;
    x_rd_addr_nx = x_rd_addr;
    // x_zero follows the read strobe by one cycle, matching the buffer read latency.
    x_zero_nx    = ~x_rd_en;
    capture      = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx     = CLEAR;
          n_lat_nx     = n_vec;
          busy_nx      = 1'b1;
          dp_clr_nx    = 1'b1;
          dp_en_nx     = 1'b1;
          x_rd_addr_nx = '0;
          cnt_nx       = '0;
        end
      end
      CLEAR: begin
        x_rd_addr_nx = '0;
        cnt_nx       = '0;
        if (n_lat == '0) begin
          state_nx   = DRAIN;
          x_rd_en_nx = 1'b0;
        end else begin
          state_nx   = FEED;
          x_rd_en_nx = 1'b1;
        end
      end
      FEED: begin
        // The read address doubles as the feed counter.
        if (x_rd_addr == n_lat - AW'(1)) begin
          state_nx   = DRAIN;
          x_rd_en_nx = 1'b0;
          cnt_nx     = '0;
        end else begin
          x_rd_addr_nx = x_rd_addr + AW'(1);
        end
      end
      DRAIN: begin
        if (cnt == CW'(DP_LAT - 1)) begin
          state_nx = IDLE;
          capture  = 1'b1;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          dp_en_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort overrides everything outside IDLE: quiet the datapath and skip the capture.
    if (abort && state != IDLE) begin
      state_nx   = IDLE;
      busy_nx    = 1'b0;
      done_nx    = 1'b0;
      dp_en_nx   = 1'b0;
      dp_clr_nx  = 1'b0;
      x_rd_en_nx = 1'b0;
      x_zero_nx  = 1'b1;
      capture    = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_lat     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dp_en     <= 1'b0;
      dp_clr    <= 1'b0;
      x_rd_en   <= 1'b0;
      x_rd_addr <= '0;
      x_zero    <= 1'b1;
    end else begin
      state     <= state_nx;
      n_lat     <= n_lat_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      dp_en     <= dp_en_nx;
      dp_clr    <= dp_clr_nx;
      x_rd_en   <= x_rd_en_nx;
      x_rd_addr <= x_rd_addr_nx;
      x_zero    <= x_zero_nx;
    end
  end

  // Activation holding register: a bit-exact copy of a_in, taken on the last drain edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
    end else if (capture) begin
      a_out <= a_in;
    end
  end

endmodule

// File: tb/tb_dnn_layer_ctrl.sv
// Scoreboard bench for dnn_layer_ctrl.
// A small behavioural dnn_dp stands in for the real datapath. Each lane j
// accumulates x*w[j], with w = {1,2,3,4,-1,-2,-3,-4}.
module tb_dnn_layer_ctrl;
  localparam int DW = 16, NN = 8, AW = 8, DP_LAT = 9;

  logic              clk = 1'b0;
  logic              rst_n, start, abort;
  logic [AW-1:0]     n_vec;
  logic              busy, done, x_rd_en, x_zero, dp_en, dp_clr;
  logic [AW-1:0]     x_rd_addr;
  logic [NN*DW-1:0]  a_in, a_out;

  dnn_layer_ctrl #(.DW(DW), .NN(NN), .AW(AW), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_vec(n_vec),
    .busy(busy), .done(done), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
    .x_zero(x_zero), .dp_en(dp_en), .dp_clr(dp_clr), .a_in(a_in), .a_out(a_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural x buffer and datapath.
  logic signed [DW-1:0] xb [256];
  logic signed [DW-1:0] xd;
  logic signed [DW-1:0] acc [NN];
  int w [NN] = '{1, 2, 3, 4, -1, -2, -3, -4};

  always @(posedge clk) begin
    if (x_rd_en) xd <= xb[x_rd_addr];
    for (int j = 0; j < NN; j++) begin
      if (dp_clr) acc[j] <= '0;
      else if (dp_en) acc[j] <= acc[j] + DW'((x_zero ? 0 : int'(xd)) * w[j]);
    end
  end

  always_comb begin
    a_in = '0;
    for (int j = 0; j < NN; j++) a_in[j*DW +: DW] = acc[j];
  end

  function automatic logic [NN*DW-1:0] mk_exp(int sum);
    logic [NN*DW-1:0] e;
    e = '0;
    for (int j = 0; j < NN; j++) e[j*DW +: DW] = DW'(sum * w[j]);
    return e;
  endfunction

  typedef struct {
    int               cyc;
    int               nrd;
    logic [NN*DW-1:0] a;
  } exp_t;
  exp_t sb [$];

  int n_chk = 0, n_fail = 0;

  task automatic check(string name, logic [NN*DW-1:0] act, logic [NN*DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: read-address sequence, and done against the scoreboard.
  int rd_idx = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (x_rd_en) begin
        check("rd_addr", NN*DW'(x_rd_addr), NN*DW'(rd_idx));
        rd_idx++;
      end
      if (dp_clr) rd_idx = 0;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", NN*DW'(cyc), NN*DW'(e.cyc));
          check("read_count", NN*DW'(rd_idx), NN*DW'(e.nrd));
          check("a_out", a_out, e.a);
        end
      end
    end
  end

  task automatic wait_done(int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  // Starts a pass at the next edge; checks that dp_clr lasts exactly one cycle.
  task automatic launch(int n, int sum, bit push);
    int k;
    n_vec = AW'(n);
    start = 1'b1;
    k = cyc + 1;
    if (push) sb.push_back('{cyc: k + 1 + n + DP_LAT, nrd: n, a: mk_exp(sum)});
    @(negedge clk);
    start = 1'b0;
    check("clr_first", NN*DW'({busy, dp_clr, dp_en}), NN*DW'(3'b111));
    @(negedge clk);
    check("clr_second", NN*DW'(dp_clr), 0);
  endtask

  initial begin
    int last;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; n_vec = '0;
    for (int i = 0; i < 256; i++) xb[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset with start held high.
    check("rst_ctrl", NN*DW'({busy, done, x_rd_en, dp_en, dp_clr, x_zero}), NN*DW'(6'b000001));
    check("rst_addr", NN*DW'(x_rd_addr), 0);
    check("rst_a_out", a_out, '0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // 14 vectors, x_i = 512 - 32*i, sum 4256.
    for (int i = 0; i < 14; i++) xb[i] = DW'(512 - 32 * i);
    launch(14, 4256, 1);
    wait_done(40);
    @(negedge clk);
    check("done_single", NN*DW'(done), 0);

    // Empty pass: clear, then drain only.
    launch(0, 0, 1);
    wait_done(20);
    @(negedge clk);

    // Abort at address 5.
    n_vec = AW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (x_rd_en && x_rd_addr == AW'(5)) break;
      @(negedge clk);
    end
    check("abort_reached", NN*DW'({x_rd_en, x_rd_addr}), NN*DW'({1'b1, 8'd5}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ctrl", NN*DW'({busy, dp_en, dp_clr, x_rd_en, x_zero}), NN*DW'(5'b00001));
    repeat (20) @(negedge clk);
    check("abort_a_out", a_out, mk_exp(0));
    launch(3, 1440, 1);
    wait_done(20);
    @(negedge clk);

    // Start pulse while busy is ignored.
    launch(4, 1856, 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (20) @(negedge clk);
    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", NN*DW'({busy, dp_clr}), 0);
    repeat (15) @(negedge clk);

    // Start held high for three passes of two vectors each.
    xb[0] = 16'sd100; xb[1] = 16'sd200;
    n_vec = AW'(2); start = 1'b1;
    last = cyc + 1 + 1 + 2 + DP_LAT;
    sb.push_back('{cyc: last, nrd: 2, a: mk_exp(300)});
    wait_done(20);
    xb[0] = -16'sd50; xb[1] = 16'sd10;
    last += 13;
    sb.push_back('{cyc: last, nrd: 2, a: mk_exp(-40)});
    wait_done(20);
    xb[0] = 16'sd1000; xb[1] = 16'sd24;
    last += 13;
    sb.push_back('{cyc: last, nrd: 2, a: mk_exp(1024)});
    wait_done(20);
    start = 1'b0;
    repeat (20) @(negedge clk);

    check("sb_empty", NN*DW'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
